pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//   Parametrised program-counter generator for the RISC-V fetch stage; successor to the plain PC register.
//   Holds the PC and sequences it on a valid/ready fetch handshake.
//   Applies trap and branch redirects with fixed priority, detects misaligned branch targets,
//   supports halt/resume, and counts accepted fetches.
// PARAMETERS
//   XLEN          32    PC / address width
//   RESET_VECTOR  0     PC value loaded on reset (must be IALIGN-aligned)
//   IALIGN        4     instruction alignment in bytes: 4, or 2 for the C extension; also the sequential increment
//   CNT_W         32    width of the fetch counter
// PORTS
//   clk           in   1       clock, rising edge
//   rst           in   1       asynchronous reset, active-high
//   if_ready      in   1       fetch accepts the current PC this cycle
//   if_valid      out  1       PC output is valid for fetch
//   pc            out  XLEN    current PC
//   br_valid      in   1       branch/jump redirect request
//   br_target     in   XLEN    branch/jump target
//   trap_valid    in   1       trap/exception redirect request
//   trap_target   in   XLEN    trap handler address (mtvec base)
//   halt_req      in   1       request to stop fetching
//   resume        in   1       restart fetching after a halt
//   halted        out  1       1 while in state HALTED
//   misalign_err  out  1       1-cycle pulse: misaligned br_target rejected
//   misalign_addr out  XLEN    last rejected target (held until the next error)
//   fetch_cnt     out  CNT_W   number of accepted fetch handshakes; wraps modulo 2^CNT_W
// BEHAVIOUR
//   Reset (async, applies at any time, including mid-operation):
//     pc=RESET_VECTOR, state=BOOT, if_valid=0, halted=0, misalign_err=0, misalign_addr=0, fetch_cnt=0.
//   States:
//     BOOT    - if_valid=0. Next clock -> RUN, with pc unchanged. First fetch is RESET_VECTOR, 1 cycle after reset release.
//     RUN     - if_valid=1. Handshake = if_valid & if_ready.
//     HALTED  - if_valid=0, halted=1.
//   Next-PC priority, evaluated in RUN and HALTED:
//     1. trap_valid -> pc <= trap_target with low log2(IALIGN) bits forced to 0.
//     2. br_valid & aligned -> pc <= br_target.
//     3. br_valid & misaligned (br_target[log2(IALIGN)-1:0] != 0):
//        pc is not redirected; misalign_err=1 next cycle; misalign_addr <= br_target.
//        Sequential advance still occurs if a handshake happens that cycle.
//     4. handshake (RUN only) -> pc <= pc + IALIGN, wrapping modulo 2^XLEN (0xFFFFFFFC+4 -> 0).
//     5. otherwise pc holds (stall).
//   Redirect timing:
//     A redirect acts as a flush: it takes effect on the next clock whether or not if_ready is high.
//     fetch_cnt still increments if a handshake coincided with the redirect.
//   trap_valid with br_valid in the same cycle: trap wins; misaligned-branch check is suppressed.
//   Halt/resume:
//     halt_req in RUN -> HALTED next clock. A same-cycle handshake and any redirect are still applied.
//     resume in HALTED -> RUN next clock.
//     halt_req is ignored in HALTED and BOOT. resume is ignored in RUN and BOOT.
//     halt_req and resume together in RUN -> halt wins.
//     Redirects in HALTED update pc but do not leave HALTED.
//   Latency: input to pc/if_valid change is 1 cycle. All outputs are registered.
//   misalign_err is high for exactly one cycle per rejected branch.
// STRUCTURE
//   Shared package riscv_pkg holds:
//     XLEN default, pc_state_t enum {BOOT, RUN, HALTED}, and the RESET_VECTOR default constant.
//   Single module with no sub-module. The next-PC mux, the alignment check and the FSM are all local.
// TESTING
//   1. Reset, then release rst -> if_valid=0 for 1 cycle; then pc=0x0, if_valid=1, fetch_cnt=0.
//   2. if_ready=1 for 3 cycles -> pc 0x0 -> 0x4 -> 0x8 -> 0xC, fetch_cnt=3.
//      Drop if_ready -> pc holds 0xC.
//   3. Sequential wrap: pc=0xFFFFFFFC with a handshake -> pc=0x0.
//      With IALIGN=2: pc=0x100 with a handshake -> pc=0x102.
//   4. Redirect priority:
//      - if_ready=0, br_valid=1, br_target=0x80 -> pc=0x80 next cycle, fetch_cnt unchanged.
//      - Same cycle trap_valid=1, trap_target=0x203 -> pc=0x200.
//      - br_target=0x82 (IALIGN=4) -> pc unchanged, misalign_err pulses 1 cycle, misalign_addr=0x82.
//   5. Halt/resume:
//      - halt_req in RUN -> if_valid=0, halted=1 next cycle.
//      - br_valid to 0x40 while halted -> pc=0x40, still halted.
//      - resume -> if_valid=1, pc=0x40.
//      - halt_req+resume together in RUN -> HALTED.
//   6. Reset mid-operation: assert rst between clock edges while pc=0x12345678
//      -> pc=RESET_VECTOR and if_valid=0 immediately, without waiting for a clock edge.
//      No X on any output at any time.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V fetch-stage definitions: address width default, reset vector
// default and the PC generator state encoding.
package riscv_pkg;

  localparam int unsigned XLEN_DEFAULT         = 32;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = '0;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } pc_state_t;

endpackage

// File: rtl/pc_gen.sv
// Program-counter generator for the fetch stage: sequential advance on a
// valid/ready handshake, trap/branch redirects, misalignment reporting, halt/resume.
module pc_gen
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_DEFAULT),
  parameter int unsigned     IALIGN       = 4,
  parameter int unsigned     CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_ready,
  output logic             if_valid,
  output logic [XLEN-1:0]  pc,
  input  logic             br_valid,
  input  logic [XLEN-1:0]  br_target,
  input  logic             trap_valid,
  input  logic [XLEN-1:0]  trap_target,
  input  logic             halt_req,
  input  logic             resume,
  output logic             halted,
  output logic             misalign_err,
  output logic [XLEN-1:0]  misalign_addr,
  output logic [CNT_W-1:0] fetch_cnt
);

  localparam int unsigned ALIGN_BITS = (IALIGN == 2) ? 1 : 2;

  pc_state_t        state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic             err_q, err_d;
  logic [XLEN-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic            handshake;
  logic            redirect_ok;
  logic            br_misaligned;
  logic [XLEN-1:0] trap_pc;

  assign handshake     = (state_q == RUN) && if_ready;
  assign redirect_ok   = (state_q != BOOT);
  assign br_misaligned = (br_target[ALIGN_BITS-1:0] != '0);
  assign trap_pc       = {trap_target[XLEN-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};

  always_comb begin
    pc_d    = pc_q;
    err_d   = 1'b0;
    addr_d  = addr_q;
    cnt_d   = cnt_q + CNT_W'(handshake);
    state_d = state_q;

    // A redirect overrides the sequential step; a rejected branch does not.
    if (redirect_ok && trap_valid) begin
      pc_d = trap_pc;
    end else if (redirect_ok && br_valid && !br_misaligned) begin
      pc_d = br_target;
    end else begin
      if (redirect_ok && br_valid) begin
        err_d  = 1'b1;
        addr_d = br_target;
      end
      if (handshake) pc_d = pc_q + XLEN'(IALIGN);
    end

    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (halt_req) state_d = HALTED;
      HALTED:  if (resume)   state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      err_q   <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign if_valid      = (state_q == RUN);
  assign halted        = (state_q == HALTED);
  assign pc            = pc_q;
  assign misalign_err  = err_q;
  assign misalign_addr = addr_q;
  assign fetch_cnt     = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: one IALIGN=4 and one IALIGN=2 instance on shared inputs,
// checked against a behavioural next-PC model.
module tb_pc_gen;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        if_ready, br_valid, trap_valid, halt_req, resume;
  logic [31:0] br_target, trap_target;

  logic        o_valid[2];
  logic [31:0] o_pc[2];
  logic        o_halted[2];
  logic        o_err[2];
  logic [31:0] o_addr[2];
  logic [31:0] o_cnt[2];

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .IALIGN(4), .CNT_W(32)) u_dut4 (
    .clk(clk), .rst(rst), .if_ready(if_ready), .if_valid(o_valid[0]), .pc(o_pc[0]),
    .br_valid(br_valid), .br_target(br_target), .trap_valid(trap_valid),
    .trap_target(trap_target), .halt_req(halt_req), .resume(resume),
    .halted(o_halted[0]), .misalign_err(o_err[0]), .misalign_addr(o_addr[0]),
    .fetch_cnt(o_cnt[0])
  );

  pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0), .IALIGN(2), .CNT_W(32)) u_dut2 (
    .clk(clk), .rst(rst), .if_ready(if_ready), .if_valid(o_valid[1]), .pc(o_pc[1]),
    .br_valid(br_valid), .br_target(br_target), .trap_valid(trap_valid),
    .trap_target(trap_target), .halt_req(halt_req), .resume(resume),
    .halted(o_halted[1]), .misalign_err(o_err[1]), .misalign_addr(o_addr[1]),
    .fetch_cnt(o_cnt[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode is a string-like tag, not the RTL encoding.
  int unsigned ia[2] = '{4, 2};
  logic [31:0] m_pc[2], m_addr[2], m_cnt[2];
  logic        m_err[2];
  int          m_mode[2];  // 10 = booting, 20 = running, 30 = halted

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 32'h0; m_addr[k] = 32'h0; m_cnt[k] = 32'h0;
      m_err[k] = 1'b0; m_mode[k] = 10;
    end
  endtask

  task automatic model_clock();
    for (int k = 0; k < 2; k++) begin
      bit fetched, live;
      fetched = (m_mode[k] == 20) && if_ready;
      live    = (m_mode[k] != 10);
      if (fetched) m_cnt[k] = m_cnt[k] + 1;
      m_err[k] = 1'b0;
      if (live && trap_valid)
        m_pc[k] = trap_target - (trap_target % ia[k]);
      else if (live && br_valid && (br_target % ia[k] == 0))
        m_pc[k] = br_target;
      else begin
        if (live && br_valid) begin m_err[k] = 1'b1; m_addr[k] = br_target; end
        if (fetched) m_pc[k] = m_pc[k] + ia[k];
      end
      if (m_mode[k] == 10) m_mode[k] = 20;
      else if (m_mode[k] == 20 && halt_req) m_mode[k] = 30;
      else if (m_mode[k] == 30 && resume) m_mode[k] = 20;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic idle();
    if_ready = 0; br_valid = 0; trap_valid = 0; halt_req = 0; resume = 0;
    br_target = 32'h0; trap_target = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    repeat (2) @(posedge clk);
    #1 model_reset();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (o_pc[k] !== 32'h0 || o_valid[k] !== 1'b0 || o_halted[k] !== 1'b0 ||
          o_err[k] !== 1'b0 || o_addr[k] !== 32'h0 || o_cnt[k] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: pc=%h v=%b h=%b e=%b a=%h c=%h, need all zero",
                 k, o_pc[k], o_valid[k], o_halted[k], o_err[k], o_addr[k], o_cnt[k]);
      end
    end
    @(negedge clk) rst = 1'b0;
    #1;
    n_checks++;
    if (o_valid[0] !== 1'b0) begin
      n_fail++; $display("FAIL boot_invalid: if_valid=%b need 0", o_valid[0]);
    end
    tick();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (o_pc[k] !== 32'h0 || o_valid[k] !== 1'b1 || o_cnt[k] !== 32'h0) begin
        n_fail++;
        $display("FAIL first_fetch dut%0d: pc=%h v=%b c=%h, need pc=0 v=1 c=0",
                 k, o_pc[k], o_valid[k], o_cnt[k]);
      end
    end
  endtask

  task automatic test_sequential();
    if_ready = 1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++;
      if (o_pc[0] !== 32'(4 * i) || o_pc[1] !== 32'(2 * i)) begin
        n_fail++;
        $display("FAIL seq_step%0d: pc4=%h pc2=%h, need %h %h", i, o_pc[0], o_pc[1], 4 * i, 2 * i);
      end
    end
    n_checks++;
    if (o_cnt[0] !== 32'd3 || o_cnt[1] !== 32'd3) begin
      n_fail++; $display("FAIL seq_count: cnt=%0d/%0d need 3", o_cnt[0], o_cnt[1]);
    end
    if_ready = 0;
    tick(); tick();
    n_checks++;
    if (o_pc[0] !== 32'hC || o_pc[1] !== 32'h6 || o_cnt[0] !== 32'd3) begin
      n_fail++; $display("FAIL stall_hold: pc4=%h pc2=%h cnt=%0d need C 6 3", o_pc[0], o_pc[1], o_cnt[0]);
    end
  endtask

  task automatic test_wrap();
    br_valid = 1; br_target = 32'hFFFF_FFFC;
    tick();
    br_valid = 0; if_ready = 1;
    tick();
    n_checks++;
    if (o_pc[0] !== 32'h0 || o_pc[1] !== 32'hFFFF_FFFE) begin
      n_fail++; $display("FAIL wrap: pc4=%h pc2=%h need 0 FFFFFFFE", o_pc[0], o_pc[1]);
    end
    if_ready = 0; br_valid = 1; br_target = 32'h100;
    tick();
    br_valid = 0; if_ready = 1;
    tick();
    if_ready = 0;
    n_checks++;
    if (o_pc[0] !== 32'h104 || o_pc[1] !== 32'h102) begin
      n_fail++; $display("FAIL ialign_step: pc4=%h pc2=%h need 104 102", o_pc[0], o_pc[1]);
    end
  endtask

  task automatic test_redirect();
    logic [31:0] cnt0;
    cnt0 = o_cnt[0];
    br_valid = 1; br_target = 32'h80;
    tick();
    n_checks++;
    if (o_pc[0] !== 32'h80 || o_cnt[0] !== cnt0) begin
      n_fail++; $display("FAIL branch_stalled: pc=%h cnt=%0d need 80 %0d", o_pc[0], o_cnt[0], cnt0);
    end
    trap_valid = 1; trap_target = 32'h203; br_target = 32'h81;
    tick();
    trap_valid = 0;
    n_checks++;
    if (o_pc[0] !== 32'h200 || o_pc[1] !== 32'h202 || o_err[0] !== 1'b0) begin
      n_fail++; $display("FAIL trap_priority: pc4=%h pc2=%h err=%b need 200 202 0", o_pc[0], o_pc[1], o_err[0]);
    end
    br_target = 32'h82;
    tick();
    br_valid = 0;
    n_checks++;
    if (o_pc[0] !== 32'h200 || o_err[0] !== 1'b1 || o_addr[0] !== 32'h82 ||
        o_pc[1] !== 32'h82 || o_err[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL misalign: pc4=%h err4=%b addr4=%h pc2=%h err2=%b need 200 1 82 82 0",
               o_pc[0], o_err[0], o_addr[0], o_pc[1], o_err[1]);
    end
    tick();
    n_checks++;
    if (o_err[0] !== 1'b0 || o_addr[0] !== 32'h82) begin
      n_fail++; $display("FAIL misalign_pulse: err=%b addr=%h need 0 82", o_err[0], o_addr[0]);
    end
    br_valid = 1; br_target = 32'h31; if_ready = 1;
    tick();
    br_valid = 0; if_ready = 0;
    n_checks++;
    if (o_pc[0] !== 32'h204 || o_pc[1] !== 32'h84 || o_err[1] !== 1'b1 || o_addr[1] !== 32'h31) begin
      n_fail++;
      $display("FAIL misalign_advance: pc4=%h pc2=%h err2=%b addr2=%h need 204 84 1 31",
               o_pc[0], o_pc[1], o_err[1], o_addr[1]);
    end
  endtask

  task automatic test_halt();
    halt_req = 1; if_ready = 1;
    tick();
    halt_req = 0; if_ready = 0;
    n_checks++;
    if (o_halted[0] !== 1'b1 || o_valid[0] !== 1'b0 || o_pc[0] !== 32'h208) begin
      n_fail++; $display("FAIL halt_enter: h=%b v=%b pc=%h need 1 0 208", o_halted[0], o_valid[0], o_pc[0]);
    end
    br_valid = 1; br_target = 32'h40; if_ready = 1;
    tick();
    br_valid = 0; if_ready = 0;
    n_checks++;
    if (o_pc[0] !== 32'h40 || o_halted[0] !== 1'b1) begin
      n_fail++; $display("FAIL halted_redirect: pc=%h h=%b need 40 1", o_pc[0], o_halted[0]);
    end
    resume = 1;
    tick();
    resume = 0;
    n_checks++;
    if (o_valid[0] !== 1'b1 || o_halted[0] !== 1'b0 || o_pc[0] !== 32'h40) begin
      n_fail++; $display("FAIL resume: v=%b h=%b pc=%h need 1 0 40", o_valid[0], o_halted[0], o_pc[0]);
    end
    halt_req = 1; resume = 1;
    tick();
    halt_req = 0; resume = 0;
    n_checks++;
    if (o_halted[0] !== 1'b1 || o_valid[0] !== 1'b0) begin
      n_fail++; $display("FAIL halt_wins: h=%b v=%b need 1 0", o_halted[0], o_valid[0]);
    end
    resume = 1;
    tick();
    resume = 0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if_ready    = ($urandom_range(0, 3) != 0);
      br_valid    = ($urandom_range(0, 3) == 0);
      trap_valid  = ($urandom_range(0, 7) == 0);
      halt_req    = ($urandom_range(0, 15) == 0);
      resume      = ($urandom_range(0, 3) == 0);
      br_target   = $urandom();
      if ($urandom_range(0, 1) == 1) br_target[1:0] = 2'b00;
      trap_target = $urandom();
      tick();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (o_pc[k] !== m_pc[k] || o_valid[k] !== (m_mode[k] == 20) ||
            o_halted[k] !== (m_mode[k] == 30) || o_err[k] !== m_err[k] ||
            o_addr[k] !== m_addr[k] || o_cnt[k] !== m_cnt[k]) begin
          n_fail++;
          $display("FAIL random c%0d dut%0d: pc=%h v=%b h=%b e=%b a=%h n=%0d need pc=%h mode=%0d e=%b a=%h n=%0d",
                   c, k, o_pc[k], o_valid[k], o_halted[k], o_err[k], o_addr[k], o_cnt[k],
                   m_pc[k], m_mode[k], m_err[k], m_addr[k], m_cnt[k]);
        end
      end
    end
    idle();
  endtask

  task automatic test_async_reset();
    idle();
    resume = 1; tick(); resume = 0;
    br_valid = 1; br_target = 32'h1234_5678;
    tick();
    br_valid = 0;
    n_checks++;
    if (o_pc[0] !== 32'h1234_5678) begin
      n_fail++; $display("FAIL pre_reset_pc: pc=%h need 12345678", o_pc[0]);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (o_pc[k] !== 32'h0 || o_valid[k] !== 1'b0 || o_halted[k] !== 1'b0 ||
          o_err[k] !== 1'b0 || o_cnt[k] !== 32'h0) begin
        n_fail++;
        $display("FAIL async_reset dut%0d: pc=%h v=%b h=%b e=%b c=%h need zeros",
                 k, o_pc[k], o_valid[k], o_halted[k], o_err[k], o_cnt[k]);
      end
    end
    model_reset();
    @(negedge clk) rst = 1'b0;
    tick();
    n_checks++;
    if (o_valid[0] !== 1'b1 || o_pc[0] !== 32'h0) begin
      n_fail++; $display("FAIL post_reset_run: v=%b pc=%h need 1 0", o_valid[0], o_pc[0]);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wrap();
    test_redirect();
    test_halt();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
